// File: rtl/apb_ram_responder.sv
// APB completer in front of a word-organised RAM: programmable wait states,
// byte strobes with byte-offset lane steering, and range/straddle error reporting.
module apb_ram_responder #(
  parameter int          APB_paddr_WIDTH = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MEM_WORDS       = 1024,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int          WAIT_STATES     = 1
) (
  input  logic                       clk,
  input  logic                       rts_n,
  input  logic [APB_paddr_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0]      APB_pdata,
  output logic [DATA_WIDTH-1:0]      APB_prdata,
  input  logic                       APB_psel,
  input  logic                       APB_penable,
  input  logic                       APB_pwrite,
  input  logic [3:0]                 APB_pstb,
  output logic                       APB_pready,
  output logic                       APB_perr
);

  localparam int          AW      = APB_paddr_WIDTH;
  localparam int          IDX_W   = $clog2(MEM_WORDS);
  localparam logic [AW:0] ADDR_LO = (AW+1)'(BASE_ADDR);
  localparam logic [AW:0] SPAN    = (AW+1)'(MEM_WORDS) << 2;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state, nxt_state;
  logic [3:0]              cnt, nxt_cnt;
  logic                    we;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic                    setup;
  logic [AW:0]             rel;
  logic                    range_err;
  logic [6:0]              stb_sh;
  logic                    stb_err;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [IDX_W-1:0]        idx_p1;
  logic [DATA_WIDTH-1:0]   wdata_p1;
  logic [3:0]              stb_p1;
  logic                    write_p1;
  logic                    err_p1;
  logic [DATA_WIDTH-1:0]   rdata_p1;

  // Setup-phase decode. A borrow out of the subtraction means below the window.
  assign setup     = (state == IDLE) && APB_psel && !APB_penable;
  assign rel       = {1'b0, APB_paddr} - ADDR_LO;
  assign range_err = rel[AW] || (rel >= SPAN);
  assign stb_sh    = 7'(APB_pstb) << APB_paddr[1:0];
  assign stb_err   = APB_pwrite && (|stb_sh[6:4]);
  // BASE_ADDR is aligned to the RAM size, so the low address bits index directly.
  assign idx       = APB_paddr[IDX_W+1:2];
  assign rd_word   = mem[idx];

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (APB_psel && !APB_penable) begin
          nxt_state = ACCESS;
          nxt_cnt   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!APB_psel) begin
          nxt_state = IDLE;
        end else if (APB_penable) begin
          if (cnt != 4'd0) nxt_cnt = cnt - 4'd1;
          else             nxt_state = IDLE;
        end
      end
    endcase
  end

  // Responses are suppressed while reset is held so the bus sees a quiet completer.
  always_comb begin
    APB_pready = 1'b0;
    APB_perr   = 1'b0;
    we         = 1'b0;
    if (rts_n) begin
      unique case (state)
        IDLE: begin
          if (APB_psel && APB_penable) begin
            APB_pready = 1'b1;
            APB_perr   = 1'b1;
          end
        end
        ACCESS: begin
          if (APB_psel && APB_penable && (cnt == 4'd0)) begin
            APB_pready = 1'b1;
            APB_perr   = err_p1;
            we         = write_p1 && !err_p1;
          end
        end
      endcase
    end
  end

  // ---- stage p1: transfer captured at the setup edge ----
  always_ff @(posedge clk) begin
    if (setup) begin
      idx_p1   <= idx;
      wdata_p1 <= APB_pdata << {APB_paddr[1:0], 3'b000};
      stb_p1   <= stb_sh[3:0];
      write_p1 <= APB_pwrite;
      err_p1   <= range_err || stb_err;
    end
  end

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      rdata_p1 <= '0;
    end else if (setup && !APB_pwrite) begin
      rdata_p1 <= range_err ? '0 : (rd_word >> {APB_paddr[1:0], 3'b000});
    end
  end

  assign APB_prdata = rdata_p1;

  // ---- RAM write port: commits on the edge that ends the completion cycle ----
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (stb_p1[i]) mem[idx_p1][8*i +: 8] <= wdata_p1[8*i +: 8];
      end
    end
  end

endmodule
